dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, the word-address width driven to the RAM (byte addr bits [ADDR_W+1:2]).
REQ-002 SHALL use one clock; reset is asynchronous and active-low; ports are named clk and rst_n.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 pN_req  in  1  requester N (N=0 core data port, N=1 debug/loader port) has a valid access.
REQ-006 pN_lock  in  1  requester N wants to keep ownership after this access.
REQ-007 pN_op  in  1  0=read, 1=write.
REQ-008 pN_addr  in  32  byte address.
REQ-009 pN_mask  in  4  byte-lane write enables.
REQ-010 pN_wdata  in  32  write data.
REQ-011 pN_gnt  out  1  access from requester N is accepted this cycle.
REQ-012 pN_rvalid  out  1  read data for requester N is valid.
REQ-013 pN_rdata  out  32  read data.
REQ-014 mem_en  out  1  RAM access strobe.
REQ-015 mem_addr  out  ADDR_W  RAM word index.
REQ-016 mem_op  out  1  RAM read/write select.
REQ-017 mem_mask  out  4  RAM byte-lane enables.
REQ-018 mem_wdata  out  32  RAM write data.
REQ-019 mem_rdata  in  32  RAM read data, valid one cycle after a read strobe.

Function
REQ-020 Handshake: an access is accepted in a cycle with pN_req=1 and pN_gnt=1; pN_gnt is combinational from current state and requests, and at most one grant is 1 per cycle.
REQ-021 On acceptance, mem_* mirror the winner's op/mask/wdata in the same cycle, mem_en=1, mem_addr=pN_addr[ADDR_W+1:2]; higher address bits are ignored.
REQ-022 With no grant, mem_en=0, mem_op=0, mem_mask=0.
REQ-023 Read latency: pN_rvalid=1 exactly one cycle after the accepted read, with pN_rdata=mem_rdata; writes produce no rvalid.
REQ-024 pN_rdata SHALL be 0 when pN_rvalid=0.
REQ-025 State machine: IDLE (no owner), LOCK0, LOCK1.
REQ-026 IDLE -> LOCKN when requester N is accepted with pN_lock=1.
REQ-027 LOCKN -> IDLE when requester N is accepted with pN_lock=0, or when pN_req=0 for a cycle.
REQ-028 In LOCKN only requester N may be granted; the other requester's gnt stays 0.
REQ-029 Read-with-mask-0 and write-with-mask-0 SHALL still be granted; mask is passed unchanged.
REQ-030 Back-to-back accesses, including alternating ports, SHALL be accepted every cycle with no bubble.

Reset
REQ-031 Asserting rst_n low SHALL force IDLE, clear the round-robin pointer to "last=1" (port 0 preferred next), and drive all gnt, rvalid and rdata outputs and mem_en to 0.
REQ-032 A read accepted in the cycle before reset asserts SHALL produce no rvalid after reset.

Configuration
REQ-033 With DMEM_ARB_RR_EN defined, IDLE conflicts SHALL be resolved round-robin: grant the port not granted most recently.
REQ-034 Without DMEM_ARB_RR_EN, IDLE conflicts SHALL always grant port 0 (fixed priority); the pointer register SHALL be absent.

Structure
REQ-035 A shared package dmem_arb_pkg SHALL hold the state enum (IDLE/LOCK0/LOCK1) and the op encodings (MEM_OP_READ=0, MEM_OP_WRITE=1).
REQ-036 The arbitration decision SHALL be one sub-module dmem_arb_pick (requests, lock state, pointer -> one-hot grant); everything else stays in dmem_arbiter.

Verification
REQ-037 p0 read only, addr 0x1000, mem_rdata=0xDEADBEEF -> p0_gnt=1, mem_addr=0x400; next cycle p0_rvalid=1, p0_rdata=0xDEADBEEF.
REQ-038 Both ports write in the same cycle, repeated 4 cycles, RR enabled -> grants alternate 0,1,0,1; RR disabled -> p0 granted all 4 cycles.
REQ-039 p1 write with lock=1 for 3 cycles while p0 requests -> p0_gnt=0 for all 3; after p1 lock=0 access, p0 is granted on the next cycle.
REQ-040 p1 locked, then p1_req drops for one cycle -> IDLE; p0 is granted in that same cycle.
REQ-041 p0 read accepted, rst_n pulsed low on the next edge -> p0_rvalid stays 0; all outputs read 0 during reset.
REQ-042 p0 sb-style write, mask 4'b0100, wdata 0x00780000 -> mem_mask=4'b0100, mem_wdata=0x00780000, no rvalid.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and encodings for the data-memory arbiter
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    localparam logic MEM_OP_READ  = 1'b0;
    localparam logic MEM_OP_WRITE = 1'b1;

endpackage

// File: rtl/dmem_arb_if.sv
// rtl/dmem_arb_if.sv - requester, RAM and arbiter signal bundle with master/slave views
interface dmem_arb_if #(
    parameter int ADDR_W = 14
);
    logic              p0_req;
    logic              p0_lock;
    logic              p0_op;
    logic [31:0]       p0_addr;
    logic [3:0]        p0_mask;
    logic [31:0]       p0_wdata;
    logic              p0_gnt;
    logic              p0_rvalid;
    logic [31:0]       p0_rdata;

    logic              p1_req;
    logic              p1_lock;
    logic              p1_op;
    logic [31:0]       p1_addr;
    logic [3:0]        p1_mask;
    logic [31:0]       p1_wdata;
    logic              p1_gnt;
    logic              p1_rvalid;
    logic [31:0]       p1_rdata;

    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_op;
    logic [3:0]        mem_mask;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    // Requesters plus the RAM model drive this side.
    modport master (
        output p0_req, p0_lock, p0_op, p0_addr, p0_mask, p0_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata,
        output p1_req, p1_lock, p1_op, p1_addr, p1_mask, p1_wdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  mem_en, mem_addr, mem_op, mem_mask, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  p0_req, p0_lock, p0_op, p0_addr, p0_mask, p0_wdata,
        output p0_gnt, p0_rvalid, p0_rdata,
        input  p1_req, p1_lock, p1_op, p1_addr, p1_mask, p1_wdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output mem_en, mem_addr, mem_op, mem_mask, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - one-hot grant decision; round-robin on IDLE conflicts when DMEM_ARB_RR_EN is defined
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  arb_state_e state,
`ifdef DMEM_ARB_RR_EN
    input  logic       last,
`endif
    output logic [1:0] gnt
);

    // A lock owner that stops requesting releases the bus in the same cycle,
    // so the other port competes as if already IDLE.
    always_comb begin
        gnt = 2'b00;
        if (state == LOCK0 && req[0]) begin
            gnt = 2'b01;
        end else if (state == LOCK1 && req[1]) begin
            gnt = 2'b10;
        end else if (req == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
            gnt = last ? 2'b01 : 2'b10;
`else
            gnt = 2'b01;
`endif
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter with lock ownership and 1-cycle read return
// Optional feature macro: DMEM_ARB_RR_EN (round-robin IDLE arbitration instead of port-0 priority).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic     clk,
    input  logic     rst_n,
    dmem_arb_if.slave bus
);

    arb_state_e  state_q;
    arb_state_e  state_d;
    logic [1:0]  req;
    logic [1:0]  pick_gnt;
    logic [1:0]  gnt;
    logic [1:0]  rd_pend_q;

    logic        win_lock;
    logic        win_op;
    logic [31:0] win_addr;
    logic [3:0]  win_mask;
    logic [31:0] win_wdata;

    assign req = {bus.p1_req, bus.p0_req};

`ifdef DMEM_ARB_RR_EN
    logic last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (|gnt) begin
            last_q <= gnt[1];
        end
    end

    dmem_arb_pick u_pick (
        .req   (req),
        .state (state_q),
        .last  (last_q),
        .gnt   (pick_gnt)
    );
`else
    dmem_arb_pick u_pick (
        .req   (req),
        .state (state_q),
        .gnt   (pick_gnt)
    );
`endif

    // Grants are combinational, so they are forced low while reset is held.
    assign gnt        = pick_gnt & {2{rst_n}};
    assign bus.p0_gnt = gnt[0];
    assign bus.p1_gnt = gnt[1];

    always_comb begin
        win_lock  = 1'b0;
        win_op    = MEM_OP_READ;
        win_addr  = '0;
        win_mask  = '0;
        win_wdata = '0;
        if (gnt[0]) begin
            win_lock  = bus.p0_lock;
            win_op    = bus.p0_op;
            win_addr  = bus.p0_addr;
            win_mask  = bus.p0_mask;
            win_wdata = bus.p0_wdata;
        end else if (gnt[1]) begin
            win_lock  = bus.p1_lock;
            win_op    = bus.p1_op;
            win_addr  = bus.p1_addr;
            win_mask  = bus.p1_mask;
            win_wdata = bus.p1_wdata;
        end
    end

    assign bus.mem_en    = |gnt;
    assign bus.mem_addr  = win_addr[ADDR_W+1:2];
    assign bus.mem_op    = win_op;
    assign bus.mem_mask  = win_mask;
    assign bus.mem_wdata = win_wdata;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{win_addr[31:ADDR_W+2], win_addr[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Ownership follows the winner's lock bit; any cycle without a locking grant returns to IDLE.
    always_comb begin
        state_d = IDLE;
        if (gnt[0] && win_lock) begin
            state_d = LOCK0;
        end else if (gnt[1] && win_lock) begin
            state_d = LOCK1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q <= 2'b00;
        end else begin
            rd_pend_q <= gnt & {2{win_op == MEM_OP_READ}};
        end
    end

    assign bus.p0_rvalid = rd_pend_q[0];
    assign bus.p1_rvalid = rd_pend_q[1];
    assign bus.p0_rdata  = rd_pend_q[0] ? bus.mem_rdata : 32'h0;
    assign bus.p1_rdata  = rd_pend_q[1] ? bus.mem_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed-vector scoreboard bench for dmem_arbiter
module tb_dmem_arbiter;

    localparam logic [2:0] NONE = 3'b000;
    localparam logic [2:0] RD   = 3'b100;
    localparam logic [2:0] WR   = 3'b101;
    localparam logic [2:0] RDL  = 3'b110;
    localparam logic [2:0] WRL  = 3'b111;

    typedef struct packed {
        int          cyc;
        logic [1:0]  gnt;
        logic        en;
        logic [13:0] addr;
        logic        op;
        logic [3:0]  mask;
        logic [31:0] wdata;
        logic [1:0]  rv;
        logic [31:0] r0;
        logic [31:0] r1;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    rec_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_arb_if #(.ADDR_W(14)) bus ();

    dmem_arbiter #(.ADDR_W(14)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef DMEM_ARB_RR_EN
    localparam logic [7:0] EG38     = 8'b10_01_10_01;
    localparam logic [1:0] EG_LOCK0 = 2'b10;
`else
    localparam logic [7:0] EG38     = 8'b01_01_01_01;
    localparam logic [1:0] EG_LOCK0 = 2'b01;
`endif

    task automatic set_idle();
        {bus.p0_req, bus.p0_lock, bus.p0_op} = NONE;
        {bus.p1_req, bus.p1_lock, bus.p1_op} = NONE;
        bus.p0_addr = 0; bus.p0_mask = 0; bus.p0_wdata = 0;
        bus.p1_addr = 0; bus.p1_mask = 0; bus.p1_wdata = 0;
        bus.mem_rdata = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // One cycle of stimulus; expected response goes to the scoreboard queue.
    task automatic step(input logic [2:0] c0, input logic [31:0] a0, input logic [3:0] m0, input logic [31:0] w0,
                        input logic [2:0] c1, input logic [31:0] a1, input logic [3:0] m1, input logic [31:0] w1,
                        input logic [31:0] rd, input logic [1:0] eg, input logic [1:0] erv, input logic [31:0] er);
        rec_t r;
        @(posedge clk);
        #1;
        {bus.p0_req, bus.p0_lock, bus.p0_op} = c0;
        bus.p0_addr = a0; bus.p0_mask = m0; bus.p0_wdata = w0;
        {bus.p1_req, bus.p1_lock, bus.p1_op} = c1;
        bus.p1_addr = a1; bus.p1_mask = m1; bus.p1_wdata = w1;
        bus.mem_rdata = rd;
        if (eg != 2'b00 || erv != 2'b00) begin
            r = '0;
            r.cyc = cyc;
            r.gnt = eg;
            r.en  = |eg;
            if (eg[0]) begin
                r.addr = a0[15:2]; r.op = c0[0]; r.mask = m0; r.wdata = w0;
            end else if (eg[1]) begin
                r.addr = a1[15:2]; r.op = c1[0]; r.mask = m1; r.wdata = w1;
            end
            r.rv = erv;
            r.r0 = erv[0] ? er : 32'h0;
            r.r1 = erv[1] ? er : 32'h0;
            exp_q.push_back(r);
        end
    endtask

    task automatic idle_step();
        step(NONE, 0, 0, 0, NONE, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    endtask

    always @(negedge clk) begin
        rec_t a;
        rec_t e;
        if (rst_n === 1'b1) begin
            n_cmp++;
            if (bus.p0_gnt || bus.p1_gnt || bus.mem_en || bus.p0_rvalid || bus.p1_rvalid) begin
                a.cyc = cyc;
                a.gnt = {bus.p1_gnt, bus.p0_gnt};
                a.en = bus.mem_en; a.addr = bus.mem_addr; a.op = bus.mem_op;
                a.mask = bus.mem_mask; a.wdata = bus.mem_wdata;
                a.rv = {bus.p1_rvalid, bus.p0_rvalid};
                a.r0 = bus.p0_rdata; a.r1 = bus.p1_rdata;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_activity cyc=%0d: got gnt=%b rv=%b en=%b required no activity",
                             cyc, a.gnt, a.rv, a.en);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        n_bad++;
                        $display("FAIL scoreboard: got cyc=%0d gnt=%b en=%b addr=%h op=%b mask=%b wdata=%h rv=%b r0=%h r1=%h required cyc=%0d gnt=%b en=%b addr=%h op=%b mask=%b wdata=%h rv=%b r0=%h r1=%h",
                                 a.cyc, a.gnt, a.en, a.addr, a.op, a.mask, a.wdata, a.rv, a.r0, a.r1,
                                 e.cyc, e.gnt, e.en, e.addr, e.op, e.mask, e.wdata, e.rv, e.r0, e.r1);
                    end
                end
            end else if (bus.mem_op !== 1'b0 || bus.mem_mask !== 4'b0000) begin
                n_bad++;
                $display("FAIL idle_mem cyc=%0d: got op=%b mask=%b required op=0 mask=0000",
                         cyc, bus.mem_op, bus.mem_mask);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        set_idle();
        bus.p0_req = 1'b1;
        bus.p1_req = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        chk("reset_ctl", {27'd0, bus.p1_gnt, bus.p0_gnt, bus.mem_en, bus.p1_rvalid, bus.p0_rvalid}, 32'h0);
        chk("reset_rdata0", bus.p0_rdata, 32'h0);
        chk("reset_rdata1", bus.p1_rdata, 32'h0);
        @(posedge clk);
        #1;
        set_idle();
        rst_n = 1'b1;

        // Single p0 read with 1-cycle return
        step(RD, 32'h1000, 4'hF, 0, NONE, 0, 0, 0, 0, 2'b01, 2'b00, 0);
        step(NONE, 0, 0, 0, NONE, 0, 0, 0, 32'hDEAD_BEEF, 2'b00, 2'b01, 32'hDEAD_BEEF);

        // Alternating back-to-back accesses, high address bits ignored
        step(RD, 32'h8, 4'hF, 0, NONE, 0, 0, 0, 0, 2'b01, 2'b00, 0);
        step(NONE, 0, 0, 0, RD, 32'hFFFF_1004, 4'hF, 0, 32'h1111_1111, 2'b10, 2'b01, 32'h1111_1111);
        step(WR, 32'h10, 4'hF, 32'hCAFE_F00D, NONE, 0, 0, 0, 32'h2222_2222, 2'b01, 2'b10, 32'h2222_2222);
        idle_step();

        // Byte write, then a mask-0 read on p1
        step(WR, 32'h24, 4'b0100, 32'h0078_0000, NONE, 0, 0, 0, 0, 2'b01, 2'b00, 0);
        idle_step();
        step(NONE, 0, 0, 0, RD, 32'h4, 4'h0, 0, 0, 2'b10, 2'b00, 0);
        step(NONE, 0, 0, 0, NONE, 0, 0, 0, 32'h4444_4444, 2'b00, 2'b10, 32'h4444_4444);

        // Simultaneous writes for four cycles
        for (int i = 0; i < 4; i++) begin
            step(WR, 32'h100, 4'hF, 32'hA0A0_A0A0, WR, 32'h200, 4'h3, 32'hB0B0_B0B0, 0, EG38[2*i +: 2], 2'b00, 0);
        end
        step(WR, 32'h28, 4'h0, 32'h55, NONE, 0, 0, 0, 0, 2'b01, 2'b00, 0);

        // p1 holds the bus with lock while p0 waits
        step(NONE, 0, 0, 0, WRL, 32'h300, 4'hF, 32'h1, 0, 2'b10, 2'b00, 0);
        for (int i = 0; i < 3; i++) begin
            step(RD, 32'h40, 4'hF, 0, WRL, 32'h304, 4'hF, 32'h2, 0, 2'b10, 2'b00, 0);
        end
        step(RD, 32'h40, 4'hF, 0, WR, 32'h308, 4'hF, 32'h3, 0, 2'b10, 2'b00, 0);
        step(RD, 32'h40, 4'hF, 0, WR, 32'h30C, 4'hF, 32'h4, 0, 2'b01, 2'b00, 0);
        step(NONE, 0, 0, 0, NONE, 0, 0, 0, 32'h5555_5555, 2'b00, 2'b01, 32'h5555_5555);

        // Lock released by p1 dropping req; p0 granted in that cycle
        step(NONE, 0, 0, 0, WRL, 32'h400, 4'hF, 32'h6, 0, 2'b10, 2'b00, 0);
        step(WR, 32'h44, 4'hF, 32'h7, NONE, 0, 0, 0, 0, 2'b01, 2'b00, 0);
        step(NONE, 0, 0, 0, WR, 32'h404, 4'hF, 32'h8, 0, 2'b10, 2'b00, 0);

        // p0 lock wins a conflict, then IDLE arbitration resumes
        step(RDL, 32'h48, 4'hF, 0, NONE, 0, 0, 0, 0, 2'b01, 2'b00, 0);
        step(WR, 32'h4C, 4'hF, 32'h9, WR, 32'h408, 4'hF, 32'hA, 32'h6666_6666, 2'b01, 2'b01, 32'h6666_6666);
        step(WR, 32'h50, 4'hF, 32'hB, WR, 32'h40C, 4'hF, 32'hC, 0, EG_LOCK0, 2'b00, 0);

        // Read accepted right before reset asserts must not return
        step(WR, 32'h54, 4'hF, 32'hD, NONE, 0, 0, 0, 0, 2'b01, 2'b00, 0);
        step(RD, 32'h58, 4'hF, 0, NONE, 0, 0, 0, 0, 2'b01, 2'b00, 0);
        #6;
        rst_n = 1'b0;
        bus.mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_pulse_ctl", {27'd0, bus.p1_gnt, bus.p0_gnt, bus.mem_en, bus.p1_rvalid, bus.p0_rvalid}, 32'h0);
            chk("rst_pulse_rdata0", bus.p0_rdata, 32'h0);
            chk("rst_pulse_mem", {bus.mem_op, bus.mem_mask, 13'd0, bus.mem_addr}, 32'h0);
        end
        @(posedge clk);
        #1;
        set_idle();
        rst_n = 1'b1;
        step(WR, 32'h5C, 4'hF, 32'hE, WR, 32'h410, 4'hF, 32'hF, 0, 2'b01, 2'b00, 0);
        idle_step();
        idle_step();

        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
